// File: rtl/metis_ep2_rx_if.sv
// Signal bundle between the UDP receive stage, the EP2 parser and its consumers.
// The master side drives the payload stream and FIFO status; the slave side is the parser.
interface metis_ep2_rx_if;
    logic        udp_active;
    logic [7:0]  udp_data;
    logic [15:0] to_port;
    logic        fifo_full;
    logic        fifo_wrreq;
    logic [7:0]  fifo_data;
    logic        frame_done;
    logic        discovery_req;
    logic        run;
    logic        wideband;
    logic        seq_error;
    logic        overflow;
    logic [15:0] err_count;

    modport master (
        output udp_active, udp_data, to_port, fifo_full,
        input  fifo_wrreq, fifo_data, frame_done, discovery_req, run, wideband,
               seq_error, overflow, err_count
    );

    modport slave (
        input  udp_active, udp_data, to_port, fifo_full,
        output fifo_wrreq, fifo_data, frame_done, discovery_req, run, wideband,
               seq_error, overflow, err_count
    );
endinterface

// File: rtl/metis_ep2_rx.sv
// HPSDR Protocol-1 (Metis) host frame parser: forwards EP2 payload to a FIFO and
// decodes discovery and start/stop requests from the UDP payload byte stream.
module metis_ep2_rx #(
    parameter logic [15:0] LISTEN_PORT = 16'd1024,
    parameter int          PAYLOAD_LEN = 1024
) (
    input logic          clock,
    input logic          reset_n,
    metis_ep2_rx_if.slave bus
);
    localparam int CNT_W = 11;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAYLOAD_LEN - 1);

    typedef enum logic [3:0] {
        IDLE, SYNC, TYPE, EP, SEQ, PAYLOAD, DISC, CMD, DISCARD
    } state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t state, state_nxt;

    logic             act;
    logic [7:0]       data;
    logic [CNT_W-1:0] cnt;
    logic [23:0]      seq_rx;
    logic [31:0]      seq_exp;
    logic [31:0]      seq_word;
    logic             seq_valid;
    logic             last;

    logic wr_nxt, done_nxt, disc_nxt, seqerr_nxt, trunc_nxt, ovf_set, cmd_ld, seq_ld;

    logic        vld_p1;
    logic [7:0]  data_p1;
    logic        done_p1;
    logic        disc_p1;
    logic        seqerr_p1;
    logic        ovf;
    logic        run_r;
    logic        wideband_r;
    logic [15:0] err_cnt;

    assign act      = bus.udp_active;
    assign data     = bus.udp_data;
    assign seq_word = {seq_rx, data};
    assign last     = (cnt == LAST_IDX);

    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Any drop of udp_active outside IDLE ends the packet, whatever state we are in.
    always_comb begin
        state_nxt = state;
        if (state != IDLE && !act) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (act) state_nxt = (bus.to_port == LISTEN_PORT && data == 8'hEF) ? SYNC : DISCARD;
                SYNC:    state_nxt = (data == 8'hFE) ? TYPE : DISCARD;
                TYPE: begin
                    case (data)
                        8'h01:   state_nxt = EP;
                        8'h02:   state_nxt = DISC;
                        8'h04:   state_nxt = CMD;
                        default: state_nxt = DISCARD;
                    endcase
                end
                EP:      state_nxt = (data == 8'h02) ? SEQ : DISCARD;
                SEQ:     if (cnt[1:0] == 2'd3) state_nxt = PAYLOAD;
                PAYLOAD: if (last) state_nxt = DISCARD;
                DISC:    state_nxt = DISCARD;
                CMD:     state_nxt = DISCARD;
                default: state_nxt = DISCARD;
            endcase
        end
    end

    // DISC fires whether or not a fourth byte arrives, so the pulse does not depend on act.
    always_comb begin
        wr_nxt     = 1'b0;
        done_nxt   = 1'b0;
        disc_nxt   = 1'b0;
        seqerr_nxt = 1'b0;
        trunc_nxt  = 1'b0;
        ovf_set    = 1'b0;
        cmd_ld     = 1'b0;
        seq_ld     = 1'b0;
        case (state)
            SEQ: begin
                if (act && cnt[1:0] == 2'd3) begin
                    seq_ld     = 1'b1;
                    seqerr_nxt = seq_valid && (seq_word != seq_exp);
                end
            end
            PAYLOAD: begin
                if (act) begin
                    wr_nxt   = !bus.fifo_full;
                    ovf_set  = bus.fifo_full;
                    done_nxt = last;
                end else begin
                    trunc_nxt = 1'b1;
                end
            end
            DISC:    disc_nxt = 1'b1;
            CMD:     cmd_ld   = act;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt <= '0;
        end else begin
            cnt <= (state_nxt == state) ? cnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge clock) begin
        if (state == SEQ && act) seq_rx <= seq_word[23:0];
        if (seq_ld)              seq_exp <= seq_word + 32'd1;
    end

    // p1: registered outputs, one cycle behind the byte that produced them
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            vld_p1     <= 1'b0;
            data_p1    <= 8'd0;
            done_p1    <= 1'b0;
            disc_p1    <= 1'b0;
            seqerr_p1  <= 1'b0;
            ovf        <= 1'b0;
            run_r      <= 1'b0;
            wideband_r <= 1'b0;
            err_cnt    <= 16'd0;
            seq_valid  <= 1'b0;
        end else begin
            vld_p1    <= wr_nxt;
            if (wr_nxt) data_p1 <= data;
            done_p1   <= done_nxt;
            disc_p1   <= disc_nxt;
            seqerr_p1 <= seqerr_nxt;
            if (ovf_set) ovf <= 1'b1;
            if (cmd_ld) begin
                run_r      <= data[0];
                wideband_r <= data[1];
            end
            if (seqerr_nxt || trunc_nxt) err_cnt <= sat_inc(err_cnt);
            if (seq_ld) seq_valid <= 1'b1;
        end
    end

    assign bus.fifo_wrreq    = vld_p1;
    assign bus.fifo_data     = data_p1;
    assign bus.frame_done    = done_p1;
    assign bus.discovery_req = disc_p1;
    assign bus.seq_error     = seqerr_p1;
    assign bus.overflow      = ovf;
    assign bus.run           = run_r;
    assign bus.wideband      = wideband_r;
    assign bus.err_count     = err_cnt;
endmodule
